// File: rtl/multicycle_ctrl.sv
// Multicycle control FSM for the RV32I-subset datapath (IF/ID/EX/MEM/WB).
// Holds the instruction register, presents the regfile addresses decoded from it
// and sequences ALU, data-memory, PC and regfile-write strobes state by state.
// Optional feature: define INSTRET_COUNTER_EN to add the retired-instruction
// counter output instret[31:0].
module multicycle_ctrl #(
  parameter int ADDR_WIDTH = 5,
  parameter int TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           instr,
  input  logic                  instr_valid,
  input  logic                  dmem_ready,
  input  logic                  zero,
  output logic [2:0]            state,
  output logic                  loadInstr,
  output logic                  loadPC,
  output logic                  PCSrc,
  output logic [ADDR_WIDTH-1:0] readReg1,
  output logic [ADDR_WIDTH-1:0] readReg2,
  output logic [ADDR_WIDTH-1:0] writeReg,
  output logic                  write,
  output logic                  ALUSrc,
  output logic [3:0]            ALUCtrl,
  output logic                  memRead,
  output logic                  memWrite,
  output logic                  memToReg,
  output logic                  illegal
`ifdef INSTRET_COUNTER_EN
  ,
  output logic [31:0]           instret
`endif
);

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EX  = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4
  } state_e;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_XOR = 4'b0101;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_SLL = 4'b1000;
  localparam logic [3:0] ALU_SRL = 4'b1001;
  localparam logic [3:0] ALU_SRA = 4'b1010;

  // Wait counter wide enough to hold TIMEOUT; stays 1 bit when waiting is unbounded.
  localparam int              CW       = $clog2(TIMEOUT + 2);
  localparam logic [CW-1:0]   CNT_LAST = CW'(TIMEOUT - 1);

  state_e        st;
  logic [31:0]   ir;
  logic [CW-1:0] cnt;
  logic          pc_upd;
  logic          beq_ex;
  logic          to_flag;

  logic [6:0]    opc;
  logic [2:0]    funct3;
  logic          f7b5;
  logic          is_r, is_i, is_lw, is_sw, is_beq, op_ok;
  logic          rd_nz;
  logic          wait_expired;
  logic [3:0]    alu_fn;

  // IR bits carrying immediates/funct7 upper bits are consumed by the datapath, not here.
  logic          unused_ir_bits;
  assign unused_ir_bits = ^{ir[31], ir[29:25]};

  assign opc    = ir[6:0];
  assign funct3 = ir[14:12];
  assign f7b5   = ir[30];

  assign is_r   = (opc == OP_R);
  assign is_i   = (opc == OP_I);
  assign is_lw  = (opc == OP_LW);
  assign is_sw  = (opc == OP_SW);
  assign is_beq = (opc == OP_BEQ);
  assign op_ok  = is_r | is_i | is_lw | is_sw | is_beq;

  assign readReg1 = ADDR_WIDTH'(ir[19:15]);
  assign readReg2 = ADDR_WIDTH'(ir[24:20]);
  assign writeReg = ADDR_WIDTH'(ir[11:7]);
  assign rd_nz    = (writeReg != '0);

  assign wait_expired = (TIMEOUT > 0) && (cnt == CNT_LAST);

  assign state     = st;
  assign loadInstr = rst && (st == S_IF) && instr_valid;
  assign PCSrc     = beq_ex && zero;
  assign loadPC    = pc_upd || ((st == S_MEM) && memWrite && dmem_ready);
  assign illegal   = to_flag || ((st == S_ID) && !op_ok);

  // ALU operation for R-type and I-ALU; funct7[5] only selects SUB (R) and SRA/SRAI.
  always_comb begin
    alu_fn = ALU_ADD;
    unique case (funct3)
      3'b000: alu_fn = (is_r && f7b5) ? ALU_SUB : ALU_ADD;
      3'b001: alu_fn = ALU_SLL;
      3'b010: alu_fn = ALU_SLT;
      3'b011: alu_fn = ALU_SLT;  // no unsigned compare on this ALU
      3'b100: alu_fn = ALU_XOR;
      3'b101: alu_fn = f7b5 ? ALU_SRA : ALU_SRL;
      3'b110: alu_fn = ALU_OR;
      3'b111: alu_fn = ALU_AND;
      default: alu_fn = ALU_ADD;
    endcase
  end

  // Sequencer: state, IR, wait counter and the state-decoded strobes, set on state entry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st       <= S_IF;
      ir       <= '0;
      cnt      <= '0;
      write    <= 1'b0;
      memToReg <= 1'b0;
      memRead  <= 1'b0;
      memWrite <= 1'b0;
      ALUSrc   <= 1'b0;
      ALUCtrl  <= '0;
      pc_upd   <= 1'b0;
      beq_ex   <= 1'b0;
      to_flag  <= 1'b0;
    end else begin
      cnt      <= '0;
      write    <= 1'b0;
      memToReg <= 1'b0;
      pc_upd   <= 1'b0;
      beq_ex   <= 1'b0;
      to_flag  <= 1'b0;
      unique case (st)
        S_IF: begin
          if (instr_valid) begin
            ir <= instr;
            st <= S_ID;
          end else if (wait_expired) begin
            to_flag <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_ID: begin
          if (op_ok) begin
            st      <= S_EX;
            ALUSrc  <= is_i | is_lw | is_sw;
            ALUCtrl <= (is_r | is_i) ? alu_fn : (is_beq ? ALU_SUB : ALU_ADD);
            pc_upd  <= is_beq;
            beq_ex  <= is_beq;
          end else begin
            st <= S_IF;
          end
        end
        S_EX: begin
          if (is_lw | is_sw) begin
            st       <= S_MEM;
            memRead  <= is_lw;
            memWrite <= is_sw;
          end else if (is_beq) begin
            st      <= S_IF;
            ALUSrc  <= 1'b0;
            ALUCtrl <= '0;
          end else begin
            st     <= S_WB;
            write  <= rd_nz;
            pc_upd <= 1'b1;
          end
        end
        S_MEM: begin
          // dmem_ready wins over an expiring wait in the same cycle.
          if (dmem_ready || wait_expired) begin
            memRead  <= 1'b0;
            memWrite <= 1'b0;
          end
          if (dmem_ready && is_lw) begin
            st       <= S_WB;
            write    <= rd_nz;
            memToReg <= 1'b1;
            pc_upd   <= 1'b1;
          end else if (dmem_ready || wait_expired) begin
            st      <= S_IF;
            ALUSrc  <= 1'b0;
            ALUCtrl <= '0;
            to_flag <= !dmem_ready;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_WB: begin
          st      <= S_IF;
          ALUSrc  <= 1'b0;
          ALUCtrl <= '0;
        end
        default: st <= S_IF;
      endcase
    end
  end

`ifdef INSTRET_COUNTER_EN
  logic retire;
  assign retire = (st == S_WB) || beq_ex || ((st == S_MEM) && memWrite && dmem_ready);

  // Retired-instruction count; wraps naturally at 2^32.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      instret <= '0;
    end else if (retire) begin
      instret <= instret + 32'd1;
    end
  end
`endif

endmodule
